// File: rtl/survivor_traceback_unit_if.sv
// Stream bundle for the survivor traceback unit:
// decision input stream plus decoded-bit output stream.
interface survivor_traceback_unit_if #(
   parameter int PM_W = 2
);
   logic            i_valid;
   logic            o_ready;
   logic [3:0]      i_dec;
   logic            i_last;
   logic [PM_W-1:0] i_PM_0;
   logic [PM_W-1:0] i_PM_1;
   logic [PM_W-1:0] i_PM_2;
   logic [PM_W-1:0] i_PM_3;
   logic            o_valid;
   logic            i_ready;
   logic            o_bit;
   logic            o_last;

   modport master (
      output i_valid, i_dec, i_last,
      output i_PM_0, i_PM_1, i_PM_2, i_PM_3,
      output i_ready,
      input  o_ready, o_valid, o_bit, o_last
   );

   modport slave (
      input  i_valid, i_dec, i_last,
      input  i_PM_0, i_PM_1, i_PM_2, i_PM_3,
      input  i_ready,
      output o_ready, o_valid, o_bit, o_last
   );
endinterface

// File: rtl/survivor_traceback_unit.sv
// Survivor memory and traceback for the K=3 Viterbi decoder.
// Buffers a frame of decisions, traces back, streams bits forward.
module survivor_traceback_unit #(
   parameter int FRAME_MAX  = 32,
   parameter int PM_W       = 2,
   parameter int TERMINATED = 1
) (
   input logic i_clk,
   input logic i_rst_n,
   survivor_traceback_unit_if.slave bus
);
   localparam int AW = $clog2(FRAME_MAX);
   localparam int LW = $clog2(FRAME_MAX + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_MAX - 1);

   typedef enum logic [1:0] {FILL, TRACE, OUTPUT} state_t;

   state_t          state;
   logic [AW-1:0]   wr_cnt;
   logic [AW-1:0]   idx;
   logic [AW-1:0]   out_idx;
   logic [LW-1:0]   len;
   logic [1:0]      st;
   logic [3:0]      mem [FRAME_MAX];
   logic [FRAME_MAX-1:0] bits;

   logic            accept;
   logic            close;
   logic            we;
   logic            trace_en;
   logic [3:0]      cur_dec;
   logic [1:0]      pred;
   logic [1:0]      min_st;
   logic [PM_W-1:0] min_pm;
   logic [PM_W-1:0] pm [4];
   logic [1:0]      start_st;
   logic [AW-1:0]   nxt_idx;

   assign pm[0] = bus.i_PM_0;
   assign pm[1] = bus.i_PM_1;
   assign pm[2] = bus.i_PM_2;
   assign pm[3] = bus.i_PM_3;

   assign accept   = bus.i_valid && bus.o_ready;
   assign close    = accept && (bus.i_last || wr_cnt == LAST_ADDR);
   assign we       = accept && i_rst_n;
   assign trace_en = (state == TRACE) && i_rst_n;
   assign cur_dec  = mem[idx];
   assign pred     = {st[0], cur_dec[st]};
   assign nxt_idx  = out_idx + 1'b1;
   assign start_st = (TERMINATED != 0) ? 2'd0 : min_st;

   // Lowest-metric state; strict compare keeps the lowest index on ties.
   always_comb begin
      min_st = 2'd0;
      min_pm = pm[0];
      for (int i = 1; i < 4; i++) begin
         if (pm[i] < min_pm) begin
            min_pm = pm[i];
            min_st = 2'(i);
         end
      end
   end

   // Decision memory and decoded-bit buffer; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (we)
         mem[wr_cnt] <= bus.i_dec;
      if (trace_en)
         bits[idx] <= st[1];
   end

   // Fill / traceback / output sequencer with registered stream outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= FILL;
         wr_cnt      <= '0;
         idx         <= '0;
         out_idx     <= '0;
         len         <= '0;
         st          <= 2'd0;
         bus.o_ready <= 1'b1;
         bus.o_valid <= 1'b0;
         bus.o_bit   <= 1'b0;
         bus.o_last  <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               if (accept)
                  wr_cnt <= wr_cnt + 1'b1;
               if (close) begin
                  len         <= LW'(wr_cnt) + 1'b1;
                  idx         <= wr_cnt;
                  st          <= start_st;
                  bus.o_ready <= 1'b0;
                  state       <= TRACE;
               end
            end
            TRACE: begin
               st  <= pred;
               idx <= idx - 1'b1;
               if (idx == '0) begin
                  // bits[0] is written on this same edge, so forward it.
                  out_idx     <= '0;
                  bus.o_valid <= 1'b1;
                  bus.o_bit   <= st[1];
                  bus.o_last  <= (len == LW'(1));
                  state       <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (bus.i_ready) begin
                  if (bus.o_last) begin
                     bus.o_valid <= 1'b0;
                     bus.o_bit   <= 1'b0;
                     bus.o_last  <= 1'b0;
                     bus.o_ready <= 1'b1;
                     wr_cnt      <= '0;
                     state       <= FILL;
                  end else begin
                     out_idx    <= nxt_idx;
                     bus.o_bit  <= bits[nxt_idx];
                     bus.o_last <= (LW'(nxt_idx) + 1'b1 == len);
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule
